// File: rtl/fetch_pc_gen_pkg.sv
`default_nettype none
// ============================================================================
//  Module      : fetch_pc_gen_pkg
//  Description : Shared MIPS fetch definitions: word type, reset vector,
//                fetch FSM state encoding and the sequential-PC helper.
//  Revision    : 1.0  initial release
// ============================================================================
package fetch_pc_gen_pkg;

   typedef logic [31:0] word_t;

   localparam word_t RESET_PC_DEFAULT = 32'hbfc0_0000;

   // Fetch FSM state encoding
   typedef logic [1:0] fetch_state_t;
   localparam fetch_state_t ST_REQ     = 2'd0;
   localparam fetch_state_t ST_WAIT    = 2'd1;
   localparam fetch_state_t ST_HOLD    = 2'd2;
   localparam fetch_state_t ST_DISCARD = 2'd3;

   // Sequential next PC; wraps modulo 2^32
   function automatic word_t next_seq_pc(input word_t pc);
      return pc + 32'd4;
   endfunction

endpackage
`default_nettype wire

// File: rtl/fetch_redirect_latch.sv
`default_nettype none
// ============================================================================
//  Module      : fetch_redirect_latch
//  Description : Records pending branch-class and exception redirects and
//                presents them merged with this cycle's requests.
//  Revision    : 1.0  initial release
// ============================================================================
module fetch_redirect_latch
   import fetch_pc_gen_pkg::*;
(
   input  logic  clk,
   input  logic  reset,
   input  logic  exception,
   input  word_t pcexception,
   input  logic  branch_taken,
   input  logic  jr,
   input  logic  jump,
   input  word_t pcbranchD,
   input  word_t pcjrD,
   input  word_t pcjumpD,
   input  logic  clear,
   output logic  exc_any,
   output word_t exc_target,
   output logic  redirect_valid,
   output word_t redirect_target
);

   logic  br_pending;
   word_t br_pending_target;
   logic  exc_pending;
   word_t exc_pending_target;

   logic  br_now;
   word_t br_now_target;
   logic  br_any;
   word_t br_target;

   // Branch-class request of this cycle with branch_taken > jr > jump priority
   always_comb begin
      br_now        = branch_taken | jr | jump;
      br_now_target = pcjumpD;
      if (branch_taken)
         br_now_target = pcbranchD;
      else if (jr)
         br_now_target = pcjrD;
   end

   // Newest request wins over the recorded one; exception beats any branch
   always_comb begin
      br_any          = br_now | br_pending;
      br_target       = br_now ? br_now_target : br_pending_target;
      exc_any         = exception | exc_pending;
      exc_target      = exception ? pcexception : exc_pending_target;
      redirect_valid  = exc_any | br_any;
      redirect_target = exc_any ? exc_target : br_target;
   end

   // Pending redirect storage, dropped once the fetch FSM consumes it
   always_ff @(posedge clk) begin
      if (reset || clear) begin
         br_pending         <= 1'b0;
         br_pending_target  <= '0;
         exc_pending        <= 1'b0;
         exc_pending_target <= '0;
      end else begin
         br_pending         <= br_any;
         br_pending_target  <= br_target;
         exc_pending        <= exc_any;
         exc_pending_target <= exc_target;
      end
   end

endmodule
`default_nettype wire

// File: rtl/fetch_pc_gen.sv
`default_nettype none
// ============================================================================
//  Module      : fetch_pc_gen
//  Description : Fetch-stage PC generator with a one-outstanding instruction
//                memory handshake, delay-slot-preserving redirects and
//                exception discard of in-flight fetches.
//  Revision    : 1.0  initial release
// ============================================================================
module fetch_pc_gen
   import fetch_pc_gen_pkg::*;
#(
   parameter word_t RESET_PC = RESET_PC_DEFAULT
)(
   input  logic  clk,
   input  logic  reset,
   input  logic  exception,
   input  word_t pcexception,
   input  logic  branch_taken,
   input  logic  jr,
   input  logic  jump,
   input  word_t pcbranchD,
   input  word_t pcjrD,
   input  word_t pcjumpD,
   input  logic  stallF,
   output logic  inst_req,
   output word_t inst_addr,
   input  logic  inst_addr_ok,
   input  logic  inst_data_ok,
   input  word_t inst_rdata,
   output word_t pcF,
   output word_t instrF,
   output logic  validF,
   output word_t pcplus4F
);

   fetch_state_t state;
   fetch_state_t state_next;
   word_t        pc;
   word_t        pc_next;
   logic         capture;
   logic         redirect_clear;

   logic         exc_any;
   word_t        exc_target;
   logic         redirect_valid;
   word_t        redirect_target;

   fetch_redirect_latch u_redirect (
      .clk             (clk),
      .reset           (reset),
      .exception       (exception),
      .pcexception     (pcexception),
      .branch_taken    (branch_taken),
      .jr              (jr),
      .jump            (jump),
      .pcbranchD       (pcbranchD),
      .pcjrD           (pcjrD),
      .pcjumpD         (pcjumpD),
      .clear           (redirect_clear),
      .exc_any         (exc_any),
      .exc_target      (exc_target),
      .redirect_valid  (redirect_valid),
      .redirect_target (redirect_target)
   );

   assign inst_req  = (state == ST_REQ);
   assign inst_addr = pc;
   assign validF    = (state == ST_HOLD);
   assign pcplus4F  = next_seq_pc(pc);

   // Next-state and next-PC selection for the fetch handshake
   always_comb begin
      state_next     = state;
      pc_next        = pc;
      capture        = 1'b0;
      redirect_clear = 1'b0;
      case (state)
         ST_REQ: begin
            // Address held until accepted; an exception turns the fetch into a discard
            if (inst_addr_ok)
               state_next = exc_any ? ST_DISCARD : ST_WAIT;
         end
         ST_WAIT: begin
            if (exc_any) begin
               if (inst_data_ok) begin
                  pc_next        = exc_target;
                  redirect_clear = 1'b1;
                  state_next     = ST_REQ;
               end else begin
                  state_next = ST_DISCARD;
               end
            end else if (inst_data_ok) begin
               capture    = 1'b1;
               state_next = ST_HOLD;
            end
         end
         ST_HOLD: begin
            if (exc_any) begin
               pc_next        = exc_target;
               redirect_clear = 1'b1;
               state_next     = ST_REQ;
            end else if (!stallF) begin
               pc_next        = redirect_valid ? redirect_target : pcplus4F;
               redirect_clear = 1'b1;
               state_next     = ST_REQ;
            end
         end
         ST_DISCARD: begin
            if (inst_data_ok) begin
               pc_next        = exc_target;
               redirect_clear = 1'b1;
               state_next     = ST_REQ;
            end
         end
         default: state_next = ST_REQ;
      endcase
   end

   // FSM, fetch PC and decode-facing instruction register
   always_ff @(posedge clk) begin
      if (reset) begin
         state  <= ST_REQ;
         pc     <= RESET_PC;
         pcF    <= '0;
         instrF <= '0;
      end else begin
         state <= state_next;
         pc    <= pc_next;
         if (capture) begin
            pcF    <= pc;
            instrF <= inst_rdata;
         end
      end
   end

endmodule
`default_nettype wire

// File: tb/tb_fetch_pc_gen.sv
`default_nettype none
// ============================================================================
//  Module      : tb_fetch_pc_gen
//  Description : Scoreboard bench for fetch_pc_gen; directed memory and
//                redirect scenarios, monitor compares addresses and deliveries.
//  Revision    : 1.0  initial release
// ============================================================================
module tb_fetch_pc_gen;

   logic        clk = 1'b0;
   logic        reset = 1'b1;
   logic        exception = 1'b0;
   logic [31:0] pcexception = '0;
   logic        branch_taken = 1'b0;
   logic        jr = 1'b0;
   logic        jump = 1'b0;
   logic [31:0] pcbranchD = '0;
   logic [31:0] pcjrD = '0;
   logic [31:0] pcjumpD = '0;
   logic        stallF = 1'b0;
   logic        inst_req;
   logic [31:0] inst_addr;
   logic        inst_addr_ok = 1'b0;
   logic        inst_data_ok = 1'b0;
   logic [31:0] inst_rdata = '0;
   logic [31:0] pcF;
   logic [31:0] instrF;
   logic        validF;
   logic [31:0] pcplus4F;

   int checks = 0;
   int errors = 0;

   logic [31:0] addr_q[$];
   logic [31:0] dpc_q[$];
   logic [31:0] dins_q[$];

   fetch_pc_gen #(.RESET_PC(32'hbfc0_0000)) dut (
      .clk          (clk),
      .reset        (reset),
      .exception    (exception),
      .pcexception  (pcexception),
      .branch_taken (branch_taken),
      .jr           (jr),
      .jump         (jump),
      .pcbranchD    (pcbranchD),
      .pcjrD        (pcjrD),
      .pcjumpD      (pcjumpD),
      .stallF       (stallF),
      .inst_req     (inst_req),
      .inst_addr    (inst_addr),
      .inst_addr_ok (inst_addr_ok),
      .inst_data_ok (inst_data_ok),
      .inst_rdata   (inst_rdata),
      .pcF          (pcF),
      .instrF       (instrF),
      .validF       (validF),
      .pcplus4F     (pcplus4F)
   );

   always #5 clk = ~clk;

   task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
      checks++;
      if (act !== exp) begin
         errors++;
         $display("FAIL %s: got %h expected %h", name, act, exp);
      end
   endtask

   // Monitor: compares address handshakes and accepted deliveries to the queues
   always @(negedge clk) begin
      if (!reset && inst_req && inst_addr_ok) begin
         if (addr_q.size() == 0) begin
            checks++; errors++;
            $display("FAIL unexpected_addr: got %h expected none", inst_addr);
         end else begin
            check("inst_addr", inst_addr, addr_q.pop_front());
         end
      end
      if (!reset && validF && !stallF) begin
         if (dpc_q.size() == 0) begin
            checks++; errors++;
            $display("FAIL unexpected_delivery: got pc %h instr %h expected none", pcF, instrF);
         end else begin
            check("pcF", pcF, dpc_q.pop_front());
            check("instrF", instrF, dins_q.pop_front());
         end
      end
   end

   task automatic step();
      @(posedge clk);
      #1;
   endtask

   task automatic addr_phase();
      int n = 0;
      while (!inst_req && n < 20) begin
         step();
         n++;
      end
      if (!inst_req) begin
         checks++; errors++;
         $display("FAIL timeout_inst_req: got 0 expected 1");
      end
      inst_addr_ok = 1'b1;
      step();
      inst_addr_ok = 1'b0;
   endtask

   task automatic data_phase(input logic [31:0] data);
      inst_data_ok = 1'b1;
      inst_rdata   = data;
      step();
      inst_data_ok = 1'b0;
      inst_rdata   = '0;
   endtask

   task automatic expect_delivery(input logic [31:0] p, input logic [31:0] i);
      dpc_q.push_back(p);
      dins_q.push_back(i);
   endtask

   initial begin
      logic [31:0] hold_pc;
      logic [31:0] hold_ins;

      // Reset and first fetch
      step(); step();
      reset = 1'b0;
      check("rst_inst_req", {31'd0, inst_req}, 32'd1);
      check("rst_inst_addr", inst_addr, 32'hbfc0_0000);
      check("rst_validF", {31'd0, validF}, 32'd0);
      check("rst_pcF", pcF, 32'd0);
      check("rst_instrF", instrF, 32'd0);
      check("rst_pcplus4F", pcplus4F, 32'hbfc0_0004);
      addr_q.push_back(32'hbfc0_0000);
      expect_delivery(32'hbfc0_0000, 32'h2408_0001);
      addr_phase();
      check("wait_no_req", {31'd0, inst_req}, 32'd0);
      step();
      data_phase(32'h2408_0001);
      check("valid_after_data", {31'd0, validF}, 32'd1);
      step();
      check("seq_next_addr", inst_addr, 32'hbfc0_0004);

      // Branch-class redirect during WAIT, newer branch overwrites older jump
      addr_q.push_back(32'hbfc0_0004);
      addr_phase();
      jump = 1'b1; pcjumpD = 32'h1111_0000;
      step();
      jump = 1'b0;
      branch_taken = 1'b1; pcbranchD = 32'h8000_0100;
      step();
      branch_taken = 1'b0;
      expect_delivery(32'hbfc0_0004, 32'h8c00_0002);
      data_phase(32'h8c00_0002);
      step();
      check("branch_target", inst_addr, 32'h8000_0100);

      // Exception during WAIT discards the returning instruction
      addr_q.push_back(32'h8000_0100);
      addr_phase();
      exception = 1'b1; pcexception = 32'hbfc0_0380;
      step();
      exception = 1'b0;
      data_phase(32'hdead_beef);
      check("discard_validF", {31'd0, validF}, 32'd0);
      check("exc_target", inst_addr, 32'hbfc0_0380);

      // Exception and jump together in HOLD: exception wins, held instr killed
      addr_q.push_back(32'hbfc0_0380);
      addr_phase();
      stallF = 1'b1;
      data_phase(32'h0000_000c);
      check("hold_validF", {31'd0, validF}, 32'd1);
      exception = 1'b1; pcexception = 32'hbfc0_0380;
      jump = 1'b1; pcjumpD = 32'h8000_0000;
      step();
      exception = 1'b0; jump = 1'b0; stallF = 1'b0;
      check("exc_hold_validF", {31'd0, validF}, 32'd0);
      check("exc_hold_req", {31'd0, inst_req}, 32'd1);
      check("exc_hold_addr", inst_addr, 32'hbfc0_0380);

      // Stall for 5 cycles in HOLD; jr beats simultaneous jump
      addr_q.push_back(32'hbfc0_0380);
      addr_phase();
      jr = 1'b1; pcjrD = 32'hffff_fffc;
      jump = 1'b1; pcjumpD = 32'h1234_5678;
      stallF = 1'b1;
      step();
      jr = 1'b0; jump = 1'b0;
      data_phase(32'h3c1d_0010);
      hold_pc  = 32'hbfc0_0380;
      hold_ins = 32'h3c1d_0010;
      for (int k = 0; k < 5; k++) begin
         check("stall_validF", {31'd0, validF}, 32'd1);
         check("stall_instrF", instrF, hold_ins);
         check("stall_pcF", pcF, hold_pc);
         check("stall_no_req", {31'd0, inst_req}, 32'd0);
         step();
      end
      stallF = 1'b0;
      expect_delivery(32'hbfc0_0380, 32'h3c1d_0010);
      step();
      check("jr_target", inst_addr, 32'hffff_fffc);
      check("wrap_pcplus4F", pcplus4F, 32'h0000_0000);

      // Wrap of the sequential PC
      addr_q.push_back(32'hffff_fffc);
      addr_phase();
      expect_delivery(32'hffff_fffc, 32'h0000_0000);
      data_phase(32'h0000_0000);
      step();
      check("wrap_addr", inst_addr, 32'h0000_0000);

      // Reset during WAIT, then a stray data_ok in REQ is ignored
      addr_q.push_back(32'h0000_0000);
      addr_phase();
      reset = 1'b1;
      step();
      reset = 1'b0;
      inst_data_ok = 1'b1; inst_rdata = 32'h1234_0000;
      step();
      inst_data_ok = 1'b0;
      check("stray_validF", {31'd0, validF}, 32'd0);
      check("stray_req", {31'd0, inst_req}, 32'd1);
      check("stray_addr", inst_addr, 32'hbfc0_0000);

      step();
      check("addr_q_empty", addr_q.size(), 32'd0);
      check("deliv_q_empty", dpc_q.size(), 32'd0);

      $display("CHECKS %0d ERRORS %0d", checks, errors);
      $finish;
   end

   // Absolute time bound
   initial begin
      #200000;
      $display("FAIL timeout: simulation did not finish");
      $fatal(1);
   end

endmodule
`default_nettype wire

// File: doc/fetch_pc_gen.md
FETCH_PC_GEN -- requirements
Module: fetch_pc_gen

Interface
REQ-001 Parameter RESET_PC, default 32'hbfc0_0000, SHALL be the first fetch address after reset.
REQ-002 clk  in  1  sole clock; all state SHALL update on its rising edge.
REQ-003 reset  in  1  synchronous, active-high reset.
REQ-004 exception / pcexception  in  1 / 32  exception redirect request and target.
REQ-005 branch_taken, jr, jump  in  1 each  decode-stage redirect requests.
REQ-006 pcbranchD, pcjrD, pcjumpD  in  32 each  matching redirect targets.
REQ-007 stallF  in  1  decode cannot accept the held instruction this cycle.
REQ-008 inst_req / inst_addr  out  1 / 32  instruction-memory request and address.
REQ-009 inst_addr_ok / inst_data_ok / inst_rdata  in  1 / 1 / 32  address accept, data return, instruction word.
REQ-010 pcF / instrF / validF  out  32 / 32 / 1  fetched PC, instruction and valid to decode.
REQ-011 pcplus4F  out  32  current fetch PC + 4.

Function
REQ-012 The block SHALL keep a fetch PC register pc and a 4-state FSM: REQ, WAIT, HOLD, DISCARD.
REQ-013 REQ: inst_req=1, inst_addr=pc; on inst_addr_ok go WAIT, or DISCARD if an exception is pending or arrives that cycle.
REQ-014 inst_addr and pc SHALL stay constant while inst_req=1 and inst_addr_ok=0.
REQ-015 WAIT: inst_req=0; on inst_data_ok capture inst_rdata and pc into instrF/pcF and go HOLD.
REQ-016 HOLD: validF=1; when stallF=0, decode accepts; pc <= pending redirect target if valid, else pc+4; clear pending; go REQ.
REQ-017 DISCARD: inst_req=0; on inst_data_ok drop the data, pc <= pending exception target, clear pending, go REQ.
REQ-018 validF SHALL be 1 only in HOLD; latency inst_data_ok -> validF is exactly 1 cycle.
REQ-019 branch_taken/jr/jump SHALL NOT discard the in-flight or held instruction (delay slot).
REQ-020 A branch/jr/jump redirect SHALL be recorded as pending; it is applied only when the current instruction is accepted.
REQ-021 Among simultaneous branch-class inputs, priority SHALL be branch_taken > jr > jump.
REQ-022 A newer branch-class redirect SHALL overwrite an older pending branch-class redirect.
REQ-023 exception SHALL override every pending or simultaneous branch-class redirect.
REQ-024 exception in REQ: record pending; exception in WAIT: go DISCARD.
REQ-025 exception in HOLD: validF=0 next cycle, pc <= pcexception, go REQ.
REQ-026 exception in DISCARD: update the pending target to the latest pcexception.
REQ-027 pcplus4F = pc + 32'd4 modulo 2^32; 32'hffff_fffc wraps to 0.
REQ-028 inst_data_ok SHALL be ignored in REQ and HOLD, and SHALL NOT be expected in the cycle of inst_addr_ok.

Reset
REQ-029 Reset SHALL force state REQ, pc=RESET_PC, pending cleared, validF=0, instrF=0, pcF=0.
REQ-030 After reset, inst_req=1 and inst_addr=RESET_PC on the first cycle.
REQ-031 Reset during WAIT/DISCARD SHALL abandon the transaction; a later stray inst_data_ok in REQ is ignored (REQ-028).

Structure
REQ-032 The FSM state enum, RESET_PC default and word_t SHALL live in the shared mips package.
REQ-033 Redirect priority and pending capture SHALL be one sub-module, fetch_redirect_latch.

Verification
REQ-034 Reset, then addr_ok at cycle 1 and data_ok at cycle 3 with 32'h2408_0001 -> cycle 4 validF=1, pcF=bfc0_0000; stallF=0 -> next inst_addr=bfc0_0004.
REQ-035 branch_taken=1, pcbranchD=8000_0100 in WAIT -> held instr delivered, then next inst_addr=8000_0100.
REQ-036 exception=1, pcexception=bfc0_0380 in WAIT -> DISCARD, data dropped (validF stays 0), next inst_addr=bfc0_0380.
REQ-037 Simultaneous exception (bfc0_0380) and jump (8000_0000) in HOLD -> validF=0 next cycle, inst_addr=bfc0_0380.
REQ-038 stallF=1 for 5 cycles in HOLD -> validF, instrF, pcF stable; no inst_req until release.
REQ-039 pc=ffff_fffc -> pcplus4F=0000_0000; after acceptance inst_addr=0000_0000.
